// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback vs. auxiliary loader, with starvation
// boost for the loader and silent discard of writes to protected registers.
module regfile_wr_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter logic [15:0] PROT_MASK    = 16'hA000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        wb_valid,
   input  logic [3:0]  wb_rd,
   input  logic [31:0] wb_wd,
   output logic        wb_ready,
   input  logic        ax_valid,
   input  logic [3:0]  ax_rd,
   input  logic [31:0] ax_wd,
   output logic        ax_ready,
   output logic        wr_enable,
   output logic [3:0]  RD,
   output logic [31:0] WD,
   output logic        drop_pulse,
   output logic        drop_src,
   output logic        boost
);

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic {NORMAL = 1'b0, BOOST = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [DW-1:0]   wd_q, wd_d;
   logic            drop_q, drop_d;
   logic            drop_src_q, drop_src_d;

   logic            acc_wb, acc_ax, acc_any, prot;
   logic [AW-1:0]   sel_rd;
   logic [DW-1:0]   sel_wd;

   // Grant: priority follows state; nothing granted under hold or reset.
   always_comb begin
      wb_ready = 1'b0;
      ax_ready = 1'b0;
      if (!rst && !hold) begin
         if (state_q == BOOST) begin
            ax_ready = ax_valid;
            wb_ready = wb_valid && !ax_valid;
         end else begin
            wb_ready = wb_valid;
            ax_ready = ax_valid && !wb_valid;
         end
      end
   end

   assign acc_wb  = wb_valid && wb_ready;
   assign acc_ax  = ax_valid && ax_ready;
   assign acc_any = acc_wb || acc_ax;
   assign sel_rd  = acc_ax ? ax_rd : wb_rd;
   assign sel_wd  = acc_ax ? ax_wd : wb_wd;
   assign prot    = PROT_MASK[sel_rd];

   always_comb begin
      starve_d   = starve_q;
      state_d    = state_q;
      wr_en_d    = acc_any && !prot;
      rd_d       = rd_q;
      wd_d       = wd_q;
      drop_d     = acc_any && prot;
      drop_src_d = drop_src_q;

      if (!ax_valid || acc_ax)
         starve_d = '0;
      else if (starve_q < LIMIT)
         starve_d = starve_q + CW'(1);

      // Boost on the edge the counter reaches the limit; leave once ax is served or idle.
      case (state_q)
         NORMAL: if (ax_valid && !acc_ax && starve_d == LIMIT) state_d = BOOST;
         BOOST:  if (!ax_valid || acc_ax) state_d = NORMAL;
         default: state_d = NORMAL;
      endcase

      if (wr_en_d) begin
         rd_d = sel_rd;
         wd_d = sel_wd;
      end
      if (drop_d)
         drop_src_d = acc_ax;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= NORMAL;
         starve_q   <= '0;
         wr_en_q    <= 1'b0;
         rd_q       <= '0;
         wd_q       <= '0;
         drop_q     <= 1'b0;
         drop_src_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         wr_en_q    <= wr_en_d;
         rd_q       <= rd_d;
         wd_q       <= wd_d;
         drop_q     <= drop_d;
         drop_src_q <= drop_src_d;
      end
   end

   assign wr_enable  = wr_en_q;
   assign RD         = rd_q;
   assign WD         = wd_q;
   assign drop_pulse = drop_q;
   assign drop_src   = drop_src_q;
   assign boost      = (state_q == BOOST);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed testbench for regfile_wr_arbiter (default parameters).
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [31:0] wb_wd;
   logic        wb_ready;
   logic        ax_valid;
   logic [3:0]  ax_rd;
   logic [31:0] ax_wd;
   logic        ax_ready;
   logic        wr_enable;
   logic [3:0]  RD;
   logic [31:0] WD;
   logic        drop_pulse;
   logic        drop_src;
   logic        boost;

   int total = 0;
   int bad   = 0;

   regfile_wr_arbiter dut (
      .clk(clk), .rst(rst), .hold(hold),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_ready(wb_ready),
      .ax_valid(ax_valid), .ax_rd(ax_rd), .ax_wd(ax_wd), .ax_ready(ax_ready),
      .wr_enable(wr_enable), .RD(RD), .WD(WD),
      .drop_pulse(drop_pulse), .drop_src(drop_src), .boost(boost)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_valid = 1'b0; ax_valid = 1'b0; hold = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0;
      wb_valid = 1'b1; wb_rd = 4'd2; wb_wd = 32'hDEAD;
      ax_valid = 1'b1; ax_rd = 4'd4; ax_wd = 32'hBEEF;
      step(); step(); #1;
      total++;
      if (wr_enable !== 1'b0 || RD !== 4'd0 || WD !== 32'd0 || drop_pulse !== 1'b0 ||
          drop_src !== 1'b0 || boost !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got we=%b rd=%0d wd=%h drop=%b src=%b boost=%b, want all 0",
                  wr_enable, RD, WD, drop_pulse, drop_src, boost);
      end
      total++;
      if (wb_ready !== 1'b0 || ax_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready: got wb_ready=%b ax_ready=%b, want 0 0", wb_ready, ax_ready);
      end
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      wb_valid = 1'b1; wb_rd = 4'd3; wb_wd = 32'h1234;
      #1;
      total++;
      if (wb_ready !== 1'b1 || ax_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_ready: got wb=%b ax=%b, want 1 0", wb_ready, ax_ready);
      end
      step();
      wb_valid = 1'b0;
      total++;
      if (wr_enable !== 1'b1 || RD !== 4'd3 || WD !== 32'h1234) begin
         bad++;
         $display("FAIL single_write: got we=%b rd=%0d wd=%h, want 1 3 00001234", wr_enable, RD, WD);
      end
      step();
      total++;
      if (wr_enable !== 1'b0 || RD !== 4'd3 || WD !== 32'h1234) begin
         bad++;
         $display("FAIL single_after: got we=%b rd=%0d wd=%h, want 0 3 00001234", wr_enable, RD, WD);
      end
   endtask

   task automatic test_starvation();
      wb_valid = 1'b1; ax_valid = 1'b1; ax_rd = 4'd7; ax_wd = 32'hA7A7;
      for (int i = 0; i < 4; i++) begin
         wb_rd = 4'(i + 1); wb_wd = 32'(i + 16'h100);
         #1;
         total++;
         if (wb_ready !== 1'b1 || ax_ready !== 1'b0 || boost !== 1'b0) begin
            bad++;
            $display("FAIL starve_wb_cycle%0d: got wb=%b ax=%b boost=%b, want 1 0 0",
                     i, wb_ready, ax_ready, boost);
         end
         step();
      end
      total++;
      if (boost !== 1'b1 || ax_ready !== 1'b1 || wb_ready !== 1'b0 || RD !== 4'd4) begin
         bad++;
         $display("FAIL starve_boost: got boost=%b ax=%b wb=%b rd=%0d, want 1 1 0 4",
                  boost, ax_ready, wb_ready, RD);
      end
      step();
      total++;
      if (boost !== 1'b0 || wr_enable !== 1'b1 || RD !== 4'd7 || WD !== 32'hA7A7 || wb_ready !== 1'b1) begin
         bad++;
         $display("FAIL starve_return: got boost=%b we=%b rd=%0d wd=%h wb=%b, want 0 1 7 0000a7a7 1",
                  boost, wr_enable, RD, WD, wb_ready);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_protect();
      ax_valid = 1'b1; ax_rd = 4'd13; ax_wd = 32'h5555;
      #1;
      total++;
      if (ax_ready !== 1'b1) begin
         bad++;
         $display("FAIL prot_ax_ready: got %b, want 1", ax_ready);
      end
      step();
      ax_valid = 1'b0;
      wb_valid = 1'b1; wb_rd = 4'd15; wb_wd = 32'h6666;
      total++;
      if (wr_enable !== 1'b0 || drop_pulse !== 1'b1 || drop_src !== 1'b1 || RD !== 4'd7) begin
         bad++;
         $display("FAIL prot_ax_drop: got we=%b drop=%b src=%b rd=%0d, want 0 1 1 7",
                  wr_enable, drop_pulse, drop_src, RD);
      end
      step();
      wb_valid = 1'b0;
      total++;
      if (wr_enable !== 1'b0 || drop_pulse !== 1'b1 || drop_src !== 1'b0 || WD !== 32'hA7A7) begin
         bad++;
         $display("FAIL prot_wb_drop: got we=%b drop=%b src=%b wd=%h, want 0 1 0 0000a7a7",
                  wr_enable, drop_pulse, drop_src, WD);
      end
      step();
      total++;
      if (drop_pulse !== 1'b0 || wr_enable !== 1'b0) begin
         bad++;
         $display("FAIL prot_pulse_end: got drop=%b we=%b, want 0 0", drop_pulse, wr_enable);
      end
   endtask

   task automatic test_hold();
      hold = 1'b1; wb_valid = 1'b1; wb_rd = 4'd8; wb_wd = 32'h8888;
      ax_valid = 1'b1; ax_rd = 4'd9; ax_wd = 32'h9999;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++;
         if (wb_ready !== 1'b0 || ax_ready !== 1'b0 || boost !== (i >= 4)) begin
            bad++;
            $display("FAIL hold_cycle%0d: got wb=%b ax=%b boost=%b, want 0 0 %b",
                     i, wb_ready, ax_ready, boost, (i >= 4));
         end
         step();
      end
      hold = 1'b0;
      #1;
      total++;
      if (ax_ready !== 1'b1 || wb_ready !== 1'b0 || boost !== 1'b1) begin
         bad++;
         $display("FAIL hold_release: got ax=%b wb=%b boost=%b, want 1 0 1", ax_ready, wb_ready, boost);
      end
      step();
      total++;
      if (wr_enable !== 1'b1 || RD !== 4'd9 || boost !== 1'b0 || wb_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_after: got we=%b rd=%0d boost=%b wb=%b, want 1 9 0 1",
                  wr_enable, RD, boost, wb_ready);
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_async_reset();
      wb_valid = 1'b1; wb_rd = 4'd5; wb_wd = 32'hCAFE;
      step();
      wb_valid = 1'b0;
      total++;
      if (wr_enable !== 1'b1 || RD !== 4'd5) begin
         bad++;
         $display("FAIL arst_pre: got we=%b rd=%0d, want 1 5", wr_enable, RD);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (wr_enable !== 1'b0 || RD !== 4'd0 || WD !== 32'd0) begin
         bad++;
         $display("FAIL arst_async: got we=%b rd=%0d wd=%h, want 0 0 00000000", wr_enable, RD, WD);
      end
      step();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (wr_enable !== 1'b0) begin
            bad++;
            $display("FAIL arst_no_write%0d: got we=%b, want 0", i, wr_enable);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 5; i++) begin
         wb_valid = 1'b1; wb_rd = 4'(i); wb_wd = 32'(i * 32'h11);
         #1;
         total++;
         if (wb_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready%0d: got %b, want 1", i, wb_ready);
         end
         step();
         total++;
         if (wr_enable !== 1'b1 || RD !== 4'(i) || WD !== 32'(i * 32'h11)) begin
            bad++;
            $display("FAIL b2b_write%0d: got we=%b rd=%0d wd=%h, want 1 %0d %h",
                     i, wr_enable, RD, WD, i, 32'(i * 32'h11));
         end
      end
      wb_valid = 1'b0;
      step();
      total++;
      if (wr_enable !== 1'b0 || RD !== 4'd5) begin
         bad++;
         $display("FAIL b2b_end: got we=%b rd=%0d, want 0 5", wr_enable, RD);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_starvation();
      test_protect();
      test_hold();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
